// File: rtl/cdce62002_spi_writer.sv
// CDCE62002 PLL register loader: shifts REG0_VAL then REG1_VAL out LSB first over a 3-wire SPI.
// Define CDCE62002_READBACK_EN to add a readback pass that compares bits [31:4] and flags error.
module cdce62002_spi_writer #(
    parameter logic [31:0] REG0_VAL = 32'h0000_0000,
    parameter logic [31:0] REG1_VAL = 32'h0000_0001,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic sysclk,
    input  logic reset_INV,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    output logic spi_clk,
    output logic spi_cs_INV,
    output logic spi_mosi,
    input  logic spi_miso
);

`ifdef CDCE62002_READBACK_EN
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE, RDCMD, RDDATA} state_t;
    localparam logic [2:0] LAST_STEP = 3'd5;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE} state_t;
    localparam logic [2:0] LAST_STEP = 3'd1;
`endif

    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic [5:0] GAP_LEN = 6'(2 * CLK_DIV);

    state_t      state;
    state_t      next_shift_state;
    logic [2:0]  step;
    logic [2:0]  next_step;
    logic [31:0] next_word;
    logic [5:0]  bit_cnt;
    logic [3:0]  div_cnt;
    logic [31:0] shreg;
    logic        armed;
    logic        shifting;

`ifdef CDCE62002_READBACK_EN
    logic [27:0] rx;
    logic        mismatch;
`else
    logic        unused_miso;
    assign unused_miso = spi_miso;
    assign error       = 1'b0;
`endif

    // Step sequence: writes of reg 0 and 1, then (readback) command/data pairs for each register.
    always_comb begin
        next_step        = step + 3'd1;
        next_word        = '0;
        next_shift_state = SHIFT;
        shifting         = (state == SHIFT);
        case (next_step)
            3'd1: next_word = REG1_VAL;
`ifdef CDCE62002_READBACK_EN
            3'd2: begin
                next_word        = {24'b0, REG0_VAL[3:0], 4'b1110};
                next_shift_state = RDCMD;
            end
            3'd3: next_shift_state = RDDATA;
            3'd4: begin
                next_word        = {24'b0, REG1_VAL[3:0], 4'b1110};
                next_shift_state = RDCMD;
            end
            3'd5: next_shift_state = RDDATA;
`endif
            default: next_word = '0;
        endcase
`ifdef CDCE62002_READBACK_EN
        shifting = (state == SHIFT) || (state == RDCMD) || (state == RDDATA);
`endif
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state      <= IDLE;
            step       <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shreg      <= '0;
            armed      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_clk    <= 1'b0;
            spi_cs_INV <= 1'b1;
            spi_mosi   <= 1'b0;
`ifdef CDCE62002_READBACK_EN
            rx         <= '0;
            mismatch   <= 1'b0;
            error      <= 1'b0;
`endif
        end else begin
            // A held start must be seen low before it can launch another sequence.
            if (!start) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start && armed) begin
                        armed      <= 1'b0;
                        state      <= SHIFT;
                        step       <= '0;
                        shreg      <= REG0_VAL;
                        spi_mosi   <= REG0_VAL[0];
                        spi_cs_INV <= 1'b0;
                        spi_clk    <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef CDCE62002_READBACK_EN
                        mismatch   <= 1'b0;
                        error      <= 1'b0;
`endif
                    end
                end
                GAP: begin
                    if (step == LAST_STEP) begin
                        if (bit_cnt == GAP_LEN) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef CDCE62002_READBACK_EN
                            error <= mismatch;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else if (bit_cnt == GAP_LEN - 6'd1) begin
                        step       <= next_step;
                        state      <= next_shift_state;
                        shreg      <= next_word;
                        spi_mosi   <= next_word[0];
                        spi_cs_INV <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                default: begin
                    if (shifting) begin
                        if (div_cnt != DIV_MAX) begin
                            div_cnt <= div_cnt + 4'd1;
                        end else begin
                            div_cnt <= '0;
                            if (!spi_clk) begin
                                spi_clk <= 1'b1;
                                bit_cnt <= bit_cnt + 6'd1;
`ifdef CDCE62002_READBACK_EN
                                if (state == RDDATA) begin
                                    rx <= {spi_miso, rx[27:1]};
                                end
`endif
                            end else begin
                                spi_clk <= 1'b0;
                                if (bit_cnt == 6'd32) begin
                                    spi_cs_INV <= 1'b1;
                                    spi_mosi   <= 1'b0;
                                    state      <= GAP;
                                    bit_cnt    <= '0;
`ifdef CDCE62002_READBACK_EN
                                    // rx now holds readback bits [31:4]; the address nibble is not compared.
                                    if (state == RDDATA &&
                                        rx != ((step == 3'd3) ? REG0_VAL[31:4] : REG1_VAL[31:4])) begin
                                        mismatch <= 1'b1;
                                    end
`endif
                                end else begin
                                    shreg    <= shreg >> 1;
                                    spi_mosi <= shreg[1];
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdce62002_spi_writer.sv
// Self-checking bench for cdce62002_spi_writer: captures SPI frames and compares against a word-level model.
// Honours CDCE62002_READBACK_EN with an echoing PLL model that can corrupt register 1 bit 9.
module tb_cdce62002_spi_writer;

    localparam int          CLK_DIV = 2;
    localparam logic [31:0] R0      = 32'hA5A5_0000;
    localparam logic [31:0] R1      = 32'h3C96_E5A1;

    logic sysclk    = 1'b0;
    logic reset_INV = 1'b0;
    logic start     = 1'b0;
    logic busy, done, error, spi_clk, spi_cs_INV, spi_mosi;
    logic spi_miso  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] fr_word[$];
    int          fr_bits[$];
    int          fr_low[$];
    logic [31:0] exp_w[$];
    int          exp_lat;

    logic [31:0] cur_word  = '0;
    int          cur_bits  = 0;
    int          low_cnt   = 0;
    int          mosi_viol = 0;
    logic        prev_clk  = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_mosi = 1'b0;

    logic        flip_bit9 = 1'b0;
    logic [31:0] pll_reg[16];
    logic [31:0] rd_word   = '0;
    logic [31:0] last_cmd  = '0;
    logic        rd_active = 1'b0;
    int          rd_idx    = 0;

    cdce62002_spi_writer #(
        .REG0_VAL(R0),
        .REG1_VAL(R1),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .sysclk    (sysclk),
        .reset_INV (reset_INV),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .spi_clk   (spi_clk),
        .spi_cs_INV(spi_cs_INV),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 sysclk = ~sysclk;

    // Bus monitor and PLL model, sampled on the falling system clock edge.
    always @(negedge sysclk) begin
        if (!spi_cs_INV) begin
            low_cnt++;
            if (spi_clk && !prev_clk) begin
                if (cur_bits < 32) cur_word[cur_bits] = spi_mosi;
                cur_bits++;
            end
        end
`ifdef CDCE62002_READBACK_EN
        if (!spi_cs_INV && prev_cs) begin
            rd_idx    = 0;
            rd_active = (fr_word.size() == 3) || (fr_word.size() == 5);
            if (rd_active) begin
                last_cmd = fr_word[$];
                rd_word  = pll_reg[last_cmd[7:4]];
                if (flip_bit9 && last_cmd[7:4] == R1[3:0]) rd_word[9] = ~rd_word[9];
            end
            spi_miso = rd_active ? rd_word[0] : 1'b0;
        end else if (!spi_cs_INV && prev_clk && !spi_clk && rd_active) begin
            rd_idx++;
            spi_miso = (rd_idx < 32) ? rd_word[rd_idx] : 1'b0;
        end
`endif
        if (spi_mosi !== prev_mosi && !(prev_clk && !spi_clk) && spi_cs_INV === prev_cs) mosi_viol++;
        if (spi_cs_INV && !prev_cs) begin
            fr_word.push_back(cur_word);
            fr_bits.push_back(cur_bits);
            fr_low.push_back(low_cnt);
`ifdef CDCE62002_READBACK_EN
            if (fr_word.size() <= 2) pll_reg[cur_word[3:0]] = cur_word;
`endif
            cur_word = '0;
            cur_bits = 0;
            low_cnt  = 0;
        end
        prev_clk  = spi_clk;
        prev_cs   = spi_cs_INV;
        prev_mosi = spi_mosi;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_frames();
        fr_word.delete();
        fr_bits.delete();
        fr_low.delete();
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_frame_count"}, fr_word.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < fr_word.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), fr_word[i], exp_w[i]);
            check($sformatf("%s_bits%0d", tag, i), fr_bits[i], 32);
            check($sformatf("%s_low%0d", tag, i), fr_low[i], 64 * CLK_DIV);
        end
    endtask

    // Drives one start request; hold = cycles start stays high, pulse_at = extra one-cycle pulse.
    task automatic run_seq(input int hold, input int pulse_at);
        int   lat;
        int   limit;
        logic prev_busy;
        limit = exp_lat + 50;
        @(negedge sysclk);
        start = 1'b1;
        @(posedge sysclk);
        #1;
        check("accept_busy", busy, 1'b1);
        check("accept_done", done, 1'b0);
        check("accept_error", error, 1'b0);
        check("accept_cs", spi_cs_INV, 1'b0);
        check("accept_mosi_bit0", spi_mosi, R0[0]);
        lat       = 0;
        prev_busy = busy;
        while (done !== 1'b1 && lat < limit) begin
            start     = (lat < hold - 1) || (lat == pulse_at);
            prev_busy = busy;
            @(posedge sysclk);
            #1;
            lat++;
        end
        check("done_latency", lat, exp_lat);
        check("busy_before_done", prev_busy, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("cs_at_done", spi_cs_INV, 1'b1);
        check("clk_at_done", spi_clk, 1'b0);
        check("mosi_at_done", spi_mosi, 1'b0);
    endtask

    initial begin
        int n;
        exp_w = {R0, R1};
`ifdef CDCE62002_READBACK_EN
        exp_w.push_back({24'b0, R0[3:0], 4'b1110});
        exp_w.push_back(32'h0);
        exp_w.push_back({24'b0, R1[3:0], 4'b1110});
        exp_w.push_back(32'h0);
`endif
        exp_lat = exp_w.size() * (64 + 2) * CLK_DIV + 1;

        repeat (3) @(posedge sysclk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_clk", spi_clk, 1'b0);
        check("reset_cs", spi_cs_INV, 1'b1);
        check("reset_mosi", spi_mosi, 1'b0);
        @(negedge sysclk);
        reset_INV = 1'b1;
        repeat ($urandom_range(5, 20)) @(posedge sysclk);
        #1;
        check("idle_quiet_frames", fr_word.size(), 0);
        check("idle_quiet_cs", spi_cs_INV, 1'b1);

        $display("[TB] single start, random width");
        clear_frames();
        run_seq(1 + $urandom_range(0, 3), -1);
        check("single_error", error, 1'b0);
        check_frames("single");

        $display("[TB] start re-pulsed on cycle 40 of word 1");
        clear_frames();
        run_seq(1, 40);
        check_frames("repulse40");

        $display("[TB] start re-pulsed at a random cycle");
        clear_frames();
        run_seq(1, $urandom_range(1, exp_lat - 2));
        check_frames("repulse_rand");

        $display("[TB] start held high");
        clear_frames();
        run_seq(1_000_000, -1);
        check_frames("held");
        repeat (exp_lat / 2) @(posedge sysclk);
        #1;
        check("held_done_stays", done, 1'b1);
        check("held_busy_low", busy, 1'b0);
        check("held_no_retrigger", fr_word.size(), exp_w.size());
        start = 1'b0;
        repeat (2) @(posedge sysclk);
        clear_frames();
        run_seq(1, -1);
        check_frames("rearm");

        $display("[TB] reset during bit 17 of word 1");
        clear_frames();
        @(negedge sysclk);
        start = 1'b1;
        @(posedge sysclk);
        #1;
        start = 1'b0;
        n = 0;
        while (cur_bits < 17 && n < 1000) begin
            @(posedge sysclk);
            n++;
        end
        check("reach_bit17", n < 1000, 1'b1);
        #3;
        reset_INV = 1'b0;
        #1;
        check("async_rst_cs", spi_cs_INV, 1'b1);
        check("async_rst_clk", spi_clk, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_mosi", spi_mosi, 1'b0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset_INV = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        clear_frames();
        repeat ($urandom_range(5, 15)) @(posedge sysclk);
        #1;
        check("post_reset_quiet", fr_word.size(), 0);
        check("post_reset_done", done, 1'b0);
        run_seq(1, -1);
        check_frames("after_reset");

`ifdef CDCE62002_READBACK_EN
        $display("[TB] readback with bit 9 of register 1 corrupted");
        flip_bit9 = 1'b1;
        clear_frames();
        run_seq(1, -1);
        check("flip_error", error, 1'b1);
        check("flip_done", done, 1'b1);
        flip_bit9 = 1'b0;
        clear_frames();
        run_seq(1, -1);
        check("echo_error", error, 1'b0);
        check_frames("echo");
`endif

        check("mosi_only_on_fall", mosi_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdce62002_spi_writer.md
CDCE62002_SPI_WRITER -- requirements
Module: cdce62002_spi_writer

Interface
REQ-001 Parameter REG0_VAL, default 32'h0000_0000, meaning: 32-bit word for CDCE62002 register 0; bits [3:0] carry the register address.
REQ-002 Parameter REG1_VAL, default 32'h0000_0001, meaning: 32-bit word for register 1; bits [3:0] carry the register address.
REQ-003 Parameter CLK_DIV, default 2, meaning: sysclk cycles per SPI clock half-period; legal range is 1..15.
REQ-004 sysclk  in  1  internal oscillator clock; all logic is on its rising edge.
REQ-005 reset_INV  in  1  asynchronous reset, active-low.
REQ-006 start  in  1  level request from the DSP sequencer to program the PLL.
REQ-007 busy  out  1  high while a transaction sequence is in progress.
REQ-008 done  out  1  high after a sequence completes; held until the next accepted start.
REQ-009 error  out  1  readback mismatch flag; valid while done is high.
REQ-010 spi_clk  out  1  SPI clock to the PLL; idles low.
REQ-011 spi_cs_INV  out  1  PLL latch enable (LE), active-low; idles high.
REQ-012 spi_mosi  out  1  serial data to the PLL, LSB first; idles low.
REQ-013 spi_miso  in  1  serial readback data from the PLL.

Function
REQ-014 States SHALL be IDLE, SHIFT, GAP, DONE, plus RDCMD and RDDATA when readback is compiled in.
REQ-015 In IDLE or DONE, start high SHALL move the block to SHIFT on the next edge, load REG0_VAL, set busy=1 and done=0, and drive spi_cs_INV=0 with spi_mosi equal to bit 0.
REQ-016 start while busy=1 SHALL be ignored; start held high after DONE SHALL NOT retrigger the sequence until it has been seen low at least once.
REQ-017 In SHIFT, spi_clk SHALL be low for CLK_DIV cycles and then high for CLK_DIV cycles per bit. spi_mosi SHALL change only on the cycle spi_clk falls.
REQ-018 After exactly 32 spi_clk rising edges, spi_clk SHALL return low and spi_cs_INV SHALL rise. The block SHALL then enter GAP with spi_cs_INV high for 2*CLK_DIV cycles.
REQ-019 Word order SHALL be REG0_VAL then REG1_VAL. After the GAP following the last write, the block SHALL go to DONE (or to RDCMD when readback is enabled).
REQ-020 In DONE: busy=0, done=1, spi_cs_INV=1, spi_clk=0, spi_mosi=0.
REQ-021 The bit counter SHALL be 6 bits and the divider counter 4 bits. Neither counter SHALL wrap within a word.
REQ-022 One write word SHALL take 64*CLK_DIV cycles from spi_cs_INV falling to spi_cs_INV rising.

Reset
REQ-023 reset_INV low SHALL immediately force IDLE with busy=0, done=0, error=0, spi_clk=0, spi_cs_INV=1, spi_mosi=0. This includes reset asserted mid-word; no partial latch pulse is then guaranteed to the PLL.
REQ-024 After reset_INV releases, no SPI activity SHALL occur until start is sampled high.

Configuration
REQ-025 Macro CDCE62002_READBACK_EN. When defined, after the writes the block SHALL read back each register in order 0 then 1. The sequence per register is:
- RDCMD: shift the 32-bit command {24'b0, addr[3:0], 4'b1110}, then GAP.
- RDDATA: hold spi_cs_INV low for 32 clocks with spi_mosi=0, sampling spi_miso on each spi_clk rising edge LSB first, then GAP.
REQ-026 With CDCE62002_READBACK_EN, error SHALL be set in DONE if sampled bits [31:4] differ from the written word's bits [31:4] for either register. error SHALL clear on the next accepted start.
REQ-027 Without CDCE62002_READBACK_EN, RDCMD and RDDATA SHALL NOT exist, spi_miso SHALL be unused, and error SHALL be constant 0.

Verification
REQ-028 CLK_DIV=2, REG0_VAL=32'hA5A5_0000, one-cycle start pulse -> first word on spi_mosi LSB first is 0,0,0,0,...,1,0,1,0,0,1,0,1; spi_cs_INV low for exactly 128 cycles; 32 rising spi_clk edges.
REQ-029 CLK_DIV=2, no readback, start pulse -> done rises 2*128+2*4+1 cycles after start sampled; busy drops the same cycle.
REQ-030 start pulsed again on cycle 40 of the first word -> waveform identical to the single-start case; exactly 2 words sent.
REQ-031 reset_INV pulled low on bit 17 of word 1 -> spi_cs_INV=1, spi_clk=0, busy=0 asynchronously; a start after release sends the full sequence from REG0_VAL.
REQ-032 CDCE62002_READBACK_EN, PLL model echoes written values -> done=1, error=0. Model flips miso bit 9 of register 1 -> done=1, error=1.
REQ-033 start held high continuously -> exactly one sequence; done stays 1. Drop start, then raise it again -> a second sequence runs and done goes 0 during it.
